// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register.
// One outstanding I-cache read at a time; a one-entry buffer absorbs a response that arrives while decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        if_id_valid,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_id_pc,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HELD   = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] req_addr, req_addr_next;
  logic [31:0] hold_ir, hold_ir_next;
  logic [31:0] hold_pc, hold_pc_next;
  logic        valid_next;
  logic [31:0] ir_next, ir_pc_next;
  logic        out_ready;
  logic [31:0] seq_addr;

  assign out_ready = !if_id_valid || !stall;
  assign seq_addr  = req_addr + 32'd4;

  // Request depends only on registered state (and reset), never on rdata or stall.
  assign imem_read    = !rst && (state != HELD);
  assign imem_address = req_addr;
  assign fsm_state    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      hold_ir     <= 32'd0;
      hold_pc     <= 32'd0;
      if_id_valid <= 1'b0;
      if_id_ir    <= 32'd0;
      if_id_pc    <= 32'd0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      req_addr    <= req_addr_next;
      hold_ir     <= hold_ir_next;
      hold_pc     <= hold_pc_next;
      if_id_valid <= valid_next;
      if_id_ir    <= ir_next;
      if_id_pc    <= ir_pc_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    hold_ir_next  = hold_ir;
    hold_pc_next  = hold_pc;
    valid_next    = if_id_valid;
    ir_next       = if_id_ir;
    ir_pc_next    = if_id_pc;

    case (state)
      FETCH: begin
        if (redirect) begin
          valid_next = 1'b0;
          pc_next    = redirect_pc;
          // The cache request cannot be withdrawn, so an unanswered one is drained in SQUASH.
          if (imem_resp) begin
            req_addr_next = redirect_pc;
          end else begin
            state_next = SQUASH;
          end
        end else if (imem_resp) begin
          pc_next       = seq_addr;
          req_addr_next = seq_addr;
          if (out_ready) begin
            valid_next = 1'b1;
            ir_next    = imem_rdata;
            ir_pc_next = req_addr;
          end else begin
            hold_ir_next = imem_rdata;
            hold_pc_next = req_addr;
            state_next   = HELD;
          end
        end
      end

      HELD: begin
        if (redirect) begin
          valid_next    = 1'b0;
          pc_next       = redirect_pc;
          req_addr_next = redirect_pc;
          state_next    = FETCH;
        end else if (!stall) begin
          valid_next = 1'b1;
          ir_next    = hold_ir;
          ir_pc_next = hold_pc;
          state_next = FETCH;
        end
      end

      SQUASH: begin
        if (redirect) begin
          valid_next = 1'b0;
          pc_next    = redirect_pc;
        end
        if (imem_resp) begin
          req_addr_next = redirect ? redirect_pc : pc;
          state_next    = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the RV32I pipeline.
- Holds the PC and issues requests to the instruction cache.
- Delivers the fetched instruction word and its PC downstream; the instruction word feeds the decode control ROM.
- Handles decode-side stalls, and EX-side redirects (taken branch, jal, jalr), including squashing an in-flight cache request.

Parameters:
RESET_PC, 32'h00000060, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  decode cannot accept a new IF/ID entry this cycle
redirect  input  1  EX resolved a control transfer; flush and refetch
redirect_pc  input  32  target PC, valid when redirect=1
imem_read  output  1  instruction cache read request
imem_address  output  32  request address; stable while imem_read=1 and no imem_resp
imem_rdata  input  32  instruction word, valid when imem_resp=1
imem_resp  input  1  single-cycle response strobe for the outstanding read
if_id_valid  output  1  IF/ID entry holds a live instruction
if_id_ir  output  32  instruction word to decode
if_id_pc  output  32  PC of if_id_ir

Behaviour:
- Registers: pc (next fetch PC), req_addr (address of the outstanding request), hold_ir/hold_pc (one-entry buffer), state, if_id_valid/ir/pc.
- Reset values: pc=RESET_PC, req_addr=RESET_PC, state=FETCH, if_id_valid=0, if_id_ir=0, if_id_pc=0, hold_*=0.
- imem_read is 0 while rst=1.
- imem_read=1 in FETCH and SQUASH, 0 in HELD. imem_address=req_addr.
- Cache protocol: once imem_read rises, it stays high and the address stays constant until imem_resp. The request is never withdrawn.
- Acceptance: out_ready = !if_id_valid || !stall.
- If the IF/ID entry is not replaced or flushed, it holds its value and valid.
- FETCH:
  - No resp: stay.
  - Resp with out_ready=1: load IF/ID with {imem_rdata, req_addr}, valid=1; pc and req_addr <= req_addr+4; stay FETCH. The next request issues the following cycle, giving 1 instruction per 2 cycles minimum with a 1-cycle cache.
  - Resp with out_ready=0: capture into hold_*; pc and req_addr <= req_addr+4; go HELD.
- HELD:
  - While stall=1 (valid is 1 here): stay, no request.
  - When stall=0: move hold_* into IF/ID; go FETCH.
- SQUASH: keep requesting the old req_addr.
  - On resp: discard data; req_addr <= pc; go FETCH.
- Redirect has priority over all other actions in the same cycle. It clears if_id_valid regardless of stall, and sets pc <= redirect_pc.
  - FETCH, no resp this cycle: go SQUASH; req_addr unchanged.
  - FETCH, resp this cycle: discard rdata; req_addr <= redirect_pc; stay FETCH.
  - HELD: discard buffer; req_addr <= redirect_pc; go FETCH.
  - SQUASH, no resp: pc updated to the newest redirect_pc; stay SQUASH.
  - SQUASH, resp: req_addr <= redirect_pc; go FETCH.
- PC arithmetic: 32-bit modulo, so 32'hFFFFFFFC+4 wraps to 0. No alignment check; redirect_pc is used as given.
- Reset mid-operation: state returns to reset values next edge regardless of an outstanding request. Any imem_resp in the reset cycle is ignored. The cache must tolerate the dropped request (cache resets together).
- No combinational path from imem_rdata or stall to imem_read/imem_address.

Test Plan:
- Reset then 1-cycle-latency cache returning 32'h00000013 at 0x60 and 0x64, stall=0 -> imem_address 0x60 then 0x64; if_id_pc 0x60 then 0x64, if_id_valid=1, if_id_ir=32'h00000013.
- stall=1 for 3 cycles while resp for 0x68 arrives, IF/ID holding 0x64 -> state HELD, imem_read=0, IF/ID unchanged; on stall=0, if_id_pc=0x68 next edge, then request 0x6C.
- redirect=1, redirect_pc=0x200, while 0x70 outstanding (resp 2 cycles later) -> if_id_valid=0 next edge; imem_address stays 0x70 until resp; data dropped; next request 0x200; first new if_id_pc=0x200.
- redirect to 0x300 in the same cycle as resp for 0x80 -> rdata discarded, no IF/ID load, next imem_address=0x300.
- Two redirects (0x400 then 0x500) during one SQUASH -> after resp, fetch address 0x500; 0x400 never requested.
- pc=32'hFFFFFFFC via redirect, resp returned -> next imem_address=0x00000000; assert rst mid-request -> pc=0x60, if_id_valid=0, imem_read=0 during rst.
